// File: rtl/hilo_multiplier_pkg.sv
// Shared definitions for the HI/LO multiplier: FSM encoding, default width
// and the controller-side opcode/funct values of the instructions it serves.
package hilo_multiplier_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // All six instructions live under the SPECIAL opcode and are told apart by funct.
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;

endpackage

// File: rtl/hilo_multiplier.sv
// Iterative shift-and-add multiplier owning the architectural HI/LO registers.
// Signed products are formed on magnitudes and negated once at the end.
module hilo_multiplier
    import hilo_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]      mcand, mplier;
    logic                  neg;
    logic [2*WIDTH-1:0]    acc, acc_step;
    logic [WIDTH:0]        partial;

    // The most negative value maps to itself, read back as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                      input logic               n);
        return n ? (~v + ONE_2W) : v;
    endfunction

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Accumulator shifts right so the adder only ever touches the upper half.
    always_comb begin
        partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_step = {partial, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= (state == S_FINISH);
            if (state == S_FINISH) begin
                {hi, lo} <= apply_sign(acc, neg);
            end else if (state == S_IDLE) begin
                if (we_hi) hi <= wdata;
                if (we_lo) lo <= wdata;
            end
        end
    end

    // Operand/accumulator registers carry no reset; they are reloaded on every start.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            mcand  <= magnitude(a, is_signed);
            mplier <= magnitude(b, is_signed);
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
        end else if (state == S_RUN) begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_hilo_multiplier.sv
// Self-checking bench for hilo_multiplier: directed table, random products
// against an arithmetic reference, and move/collision/reset/back-to-back sequences.
module tb_hilo_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a, b;
    logic        we_hi, we_lo;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    hilo_multiplier dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'h0, x};
        uy = {32'h0, y};
        return ux * uy;
    endfunction

    // Issues one multiply and follows it to done. If inject >= 0, a colliding
    // start/mthi/mtlo is driven for one cycle that many edges into the run.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input int inject);
        int          lat;
        bit          busy_ok;
        logic [63:0] held;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; is_signed = ~sgn;
        check({name, " done low after start"}, {63'h0, done}, 64'h0);
        held    = {hi, lo};
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 45) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == inject) begin
                start = 1'b1; we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h1234_5678;
                a = 32'h7; b = 32'h7;
            end
            @(posedge clk); #1;
            lat++;
            if (lat == inject + 1) begin
                start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
                check({name, " hi/lo held during run"}, {hi, lo}, held);
            end
        end
        check({name, " latency"}, 64'(lat), 64'd33);
        check({name, " busy during run"}, {63'h0, busy_ok}, 64'h1);
        check({name, " busy low at done"}, {63'h0, busy}, 64'h0);
        check({name, " product"}, {hi, lo}, exp);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{1'b1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[2] = '{1'b0, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'd1,          32'hFFFF_FFFF, 32'h8000_0000};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {busy, done, hi, lo}, {1'b0, 1'b0, 64'h0});
        @(negedge clk); reset = 1'b0;

        // Directed table; consecutive entries are back-to-back starts in the done cycle.
        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   {vecs[i].hi, vecs[i].lo}, -1);

        // mthi / mtlo in IDLE.
        @(posedge clk); #1;
        we_hi = 1'b1; wdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        we_hi = 1'b0;
        check("mthi", {32'h0, hi}, {32'h0, 32'hCAFE_BABE});
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0;
        check("mthi+mtlo", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

        // Write together with start: write lands at the start edge, product overwrites.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd10; b = 32'd11;
        we_lo = 1'b1; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        start = 1'b0; we_lo = 1'b0;
        check("write with start", {32'h0, lo}, {32'h0, 32'h5555_AAAA});
        for (int n = 0; n < 45 && !done; n++) begin
            @(posedge clk); #1;
        end
        check("product after write", {hi, lo}, 64'd110);

        // Collision during RUN: start/mthi/mtlo all ignored.
        run_op("collide", 1'b1, 32'hFFFF_FFF9, 32'd1000, model(1'b1, 32'hFFFF_FFF9, 32'd1000), 5);

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid-op", {busy, done, hi, lo}, {1'b0, 1'b0, 64'h0});
        @(negedge clk); reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check("no done after abort", {63'h0, done}, 64'h0);
        run_op("after reset", 1'b0, 32'd6, 32'd7, 64'h2A, -1);

        // Random products, back-to-back.
        for (int i = 0; i < 20; i++) begin
            logic        s;
            logic [31:0] x, y;
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op($sformatf("rand%0d", i), s, x, y, model(s, x, y), -1);
        end

        @(posedge clk); #1;
        check("done is a pulse", {63'h0, done}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
